btn_conditioner: RTL

- Front-end conditioner for the five direction buttons; sits directly upstream of the control core.
- Synchronises raw asynchronous button pins into the pixel-clock domain and debounces them with a per-button counter.
- Produces, per button, a clean level (consumed as the core's held-button inputs) and one-cycle press and release strobes (press strobe consumed as the core's down inputs).
- Replaces ad-hoc board-level debouncing; one instance serves all buttons.

---
 rtl/btn_pkg.sv | 14 +
 rtl/btn_conditioner_if.sv | 29 ++
 rtl/btn_conditioner_debounce_bit.sv | 57 +++++
 rtl/btn_conditioner.sv | 50 +++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants for the direction-button front end.
// Covers bit positions, the default button count and the debounce window.
package btn_pkg;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_U = 2;
    localparam int BTN_D = 3;
    localparam int BTN_C = 4;

    localparam int NBTN_DEFAULT   = 5;
    localparam int DEB_10MS_40MHZ = 400000;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the pins and the control core.
// The slave side is the conditioner; the master side drives the raw pins.
interface btn_conditioner_if
    import btn_pkg::*;
#(
    parameter int NBTN = NBTN_DEFAULT
);
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] btn_lvl;
    logic [NBTN-1:0] btn_dn;
    logic [NBTN-1:0] btn_up;
    logic            any_dn;

    modport master (
        output btn_raw,
        input  btn_lvl,
        input  btn_dn,
        input  btn_up,
        input  any_dn
    );

    modport slave (
        input  btn_raw,
        output btn_lvl,
        output btn_dn,
        output btn_up,
        output any_dn
    );
endinterface

// File: rtl/btn_conditioner_debounce_bit.sv
// One button: two-flop synchroniser, consecutive-cycle debounce counter,
// stable level and one-cycle press/release strobes.
module debounce_bit
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_10MS_40MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic dn,
    output logic up,
    output logic dn_next
);
    localparam int CW = $clog2(DEB_CYCLES);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          flip;
    logic          up_next;

    // The flip happens on the edge where the disagreement has lasted
    // DEB_CYCLES counted cycles; the counter clears there and never wraps.
    assign flip    = (s2 != lvl) && (cnt == CW'(DEB_CYCLES - 1));
    assign dn_next = flip && s2;
    assign up_next = flip && !s2;

    // NOTE: every flop, synchroniser included, is reset so a mid-count reset
    // cannot leave a stale count or half-synchronised value behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
            lvl <= 1'b0;
            dn  <= 1'b0;
            up  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let s2 take the old s1, forming
            // a true two-stage synchroniser regardless of statement order.
            s1 <= din;
            s2 <= s1;
            dn <= dn_next;
            up <= up_next;
            if (s2 == lvl) begin
                cnt <= '0;
            end else if (flip) begin
                lvl <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/btn_conditioner.sv
// Debounces all direction buttons into clean levels and edge strobes
// for the control core; one debounce_bit per button.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int NBTN           = NBTN_DEFAULT,
    parameter int DEB_CYCLES     = DEB_10MS_40MHZ,
    parameter bit RAW_ACTIVE_LOW = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    btn_conditioner_if.slave   io
);
    logic [NBTN-1:0] pin;
    logic [NBTN-1:0] lvl;
    logic [NBTN-1:0] dn;
    logic [NBTN-1:0] up;
    logic [NBTN-1:0] dn_next;
    logic            any_dn;

    assign pin = io.btn_raw ^ {NBTN{RAW_ACTIVE_LOW}};

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        debounce_bit #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk     (clk),
            .rst     (rst),
            .din     (pin[i]),
            .lvl     (lvl[i]),
            .dn      (dn[i]),
            .up      (up[i]),
            .dn_next (dn_next[i])
        );
    end

    // Built from the pre-register strobes so any_dn rises on the same edge as btn_dn.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            any_dn <= 1'b0;
        end else begin
            any_dn <= |dn_next;
        end
    end

    assign io.btn_lvl = lvl;
    assign io.btn_dn  = dn;
    assign io.btn_up  = up;
    assign io.any_dn  = any_dn;
endmodule
